// File: rtl/prog_lut_eval.sv
// prog_lut_eval: serially loadable N-input truth table with registered output.
// Optional PROG_LUT_HIST_EN adds a saturating count of result cycles with out_data=1.
module prog_lut_eval #(
    parameter int                   N_IN = 4,
    parameter logic [(1<<N_IN)-1:0] INIT = 16'h0777
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_start,
    input  logic            cfg_bit_valid,
    input  logic            cfg_bit,
    output logic            cfg_busy,
    output logic            cfg_done,
    input  logic            in_valid,
    input  logic [N_IN-1:0] in_data,
    output logic            in_ready,
    output logic            out_valid,
    output logic            out_data
`ifdef PROG_LUT_HIST_EN
    ,output logic [15:0]    ones_cnt
`endif
);
    localparam int DEPTH = 1 << N_IN;
    localparam logic [N_IN:0] LAST = (N_IN + 1)'(DEPTH - 1);

    typedef enum logic {RUN, LOAD} state_t;

    state_t             state_q, state_d;
    logic [N_IN:0]      cnt_q, cnt_d;
    logic [DEPTH-1:0]   lut_q, lut_d;
    logic [DEPTH-1:0]   shadow_q, shadow_d;
    logic               done_q, done_d;
    logic               ov_q, ov_d;
    logic               od_q, od_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lut_d    = lut_q;
        shadow_d = shadow_q;
        done_d   = 1'b0;
        ov_d     = 1'b0;
        od_d     = od_q;
        if (state_q == RUN) begin
            // A vector arriving with cfg_start still sees the old table.
            if (in_valid) begin
                ov_d = 1'b1;
                od_d = lut_q[in_data];
            end
            if (cfg_start) begin
                state_d = LOAD;
                cnt_d   = '0;
            end
        end else if (cfg_start) begin
            cnt_d = '0;
        end else if (cfg_bit_valid) begin
            shadow_d[cnt_q[N_IN-1:0]] = cfg_bit;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                lut_d   = shadow_d;
                state_d = RUN;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            lut_q    <= INIT;
            shadow_q <= INIT;
            done_q   <= 1'b0;
            ov_q     <= 1'b0;
            od_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lut_q    <= lut_d;
            shadow_q <= shadow_d;
            done_q   <= done_d;
            ov_q     <= ov_d;
            od_q     <= od_d;
        end
    end

    assign cfg_busy  = state_q == LOAD;
    assign in_ready  = state_q == RUN;
    assign cfg_done  = done_q;
    assign out_valid = ov_q;
    assign out_data  = od_q;

`ifdef PROG_LUT_HIST_EN
    logic [15:0] ones_q, ones_d;

    always_comb begin
        ones_d = done_q ? 16'h0 :
                 (ov_q && od_q && ones_q != 16'hFFFF) ? ones_q + 1'b1 : ones_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ones_q <= '0;
        else        ones_q <= ones_d;
    end

    assign ones_cnt = ones_q;
`endif
endmodule

// File: tb/tb_prog_lut_eval.sv
// tb_prog_lut_eval: scoreboard bench for prog_lut_eval at N_IN=4.
module tb_prog_lut_eval;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_start = 1'b0, cfg_bit_valid = 1'b0, cfg_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       cfg_busy, cfg_done, in_ready, out_valid, out_data;
`ifdef PROG_LUT_HIST_EN
    logic [15:0] ones_cnt;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model state, advanced once per rising edge by step().
    logic [15:0] m_lut, m_shadow;
    int          m_cnt;
    logic        m_load, m_done, m_ov;
    logic        exp_q[$];

    localparam logic [15:0] INIT = 16'h0777;

    prog_lut_eval dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_bit_valid(cfg_bit_valid), .cfg_bit(cfg_bit),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data)
`ifdef PROG_LUT_HIST_EN
        ,.ones_cnt(ones_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_lut = INIT; m_shadow = INIT; m_cnt = 0;
        m_load = 1'b0; m_done = 1'b0; m_ov = 1'b0;
        exp_q.delete();
    endtask

    task automatic step(input logic iv, input logic [3:0] id, input logic cs,
                        input logic bv, input logic b);
        in_valid = iv; in_data = id; cfg_start = cs; cfg_bit_valid = bv; cfg_bit = b;
        @(posedge clk);
        m_ov = 1'b0;
        m_done = 1'b0;
        if (!m_load) begin
            if (iv) begin
                exp_q.push_back(m_lut[id]);
                m_ov = 1'b1;
            end
            if (cs) begin
                m_load = 1'b1;
                m_cnt = 0;
            end
        end else if (cs) begin
            m_cnt = 0;
        end else if (bv) begin
            m_shadow[m_cnt] = b;
            if (m_cnt == 15) begin
                m_lut = m_shadow;
                m_load = 1'b0;
                m_done = 1'b1;
            end else m_cnt++;
        end
        #1;
        in_valid = 1'b0; cfg_start = 1'b0; cfg_bit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic eval(input string tag, input logic [3:0] id, input logic exp);
        step(1'b1, id, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk(tag, {31'b0, out_data}, {31'b0, exp});
    endtask

    task automatic load_word(input logic [15:0] w, input logic iv);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(iv, 4'hF, 1'b0, 1'b1, w[i]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; cfg_start = 1'b0; cfg_bit_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Continuous comparison of handshake outputs against the model; results popped from the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
                chk("cfg_busy", {31'b0, cfg_busy}, {31'b0, m_load});
                chk("in_ready", {31'b0, in_ready}, {31'b0, !m_load});
                chk("cfg_done", {31'b0, cfg_done}, {31'b0, m_done});
                if (out_valid) begin
                    if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                    else chk("out_data", {31'b0, out_data}, {31'b0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        logic [15:0] aoi_seq;
        aoi_seq = 16'b0000_0111_0111_0111;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_data", {31'b0, out_data}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, cfg_busy}, 32'd0);

        for (int i = 0; i < 16; i++) eval($sformatf("aoi_%0d", i), 4'(i), aoi_seq[i]);
        idle(2);
`ifdef PROG_LUT_HIST_EN
        chk("ones_after_aoi", {16'b0, ones_cnt}, 32'd9);
`endif

        load_word(16'h8000, 1'b0);
        @(negedge clk);
        chk("reload_done", {31'b0, cfg_done}, 32'd1);
        idle(1);
`ifdef PROG_LUT_HIST_EN
        chk("ones_cleared", {16'b0, ones_cnt}, 32'd0);
`endif
        eval("reload_f", 4'hF, 1'b1);
        eval("reload_0", 4'h0, 1'b0);

        do_reset();
        step(1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("collide_data", {31'b0, out_data}, 32'd0);
        chk("collide_busy", {31'b0, cfg_busy}, 32'd1);
        for (int i = 0; i < 16; i++) step(1'b1, 4'hF, 1'b0, 1'b1, i == 15);
        @(negedge clk);
        chk("blocked_ready", {31'b0, in_ready}, 32'd1);
        step(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("resume_valid", {31'b0, out_valid}, 32'd1);
        chk("resume_data", {31'b0, out_data}, 32'd1);

        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        load_word(16'hFFFF, 1'b0);
        idle(1);
        eval("restart_c", 4'hC, 1'b1);

        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
        do_reset();
        eval("rst_mid_c", 4'hC, 1'b0);

        idle(3);
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
